stopwatch_digit_counter: RTL

//   MM:SS stopwatch core that produces the four BCD digits driven into the

---
 rtl/stopwatch_digit_counter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_digit_counter.sv
// MM:SS stopwatch core: button synchronizers, IDLE/RUN/PAUSE control, 1 s
// prescaler and a four-digit BCD counter with a 59:59 -> 00:00 rollover pulse.
module stopwatch_digit_counter #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       rollover
);

   localparam int unsigned   PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [3:0][3:0] digit_q, digit_d;
   logic            running_q, running_d;
   logic            rollover_q, rollover_d;

   logic [1:0]      btn_w;
   logic [1:0]      press_w;
   logic            press_start_w, press_clear_w;
   logic            tick_w, clear_all_w;
   logic [3:0]      wrap_w;
   logic [4:0]      carry_w;

   assign btn_w = {btn_clear, btn_start};

   // Two-flop synchronizer plus a previous-value flop; a press is a rising edge.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_q, sync2_q, prev_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
         end else begin
            sync1_q <= btn_w[gi];
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
         end
      end

      assign press_w[gi] = sync2_q & ~prev_q;
   end

   assign press_start_w = press_w[0];
   assign press_clear_w = press_w[1];

   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      tick_w      = 1'b0;
      clear_all_w = 1'b0;
      if (press_clear_w) begin
         state_d     = ST_IDLE;
         pre_d       = '0;
         clear_all_w = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (press_start_w) state_d = ST_RUN;
            end
            ST_RUN: begin
               // The edge that leaves RUN neither counts nor ticks.
               if (press_start_w) begin
                  state_d = ST_PAUSE;
               end else if (pre_q == PRE_LAST) begin
                  pre_d  = '0;
                  tick_w = 1'b1;
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (press_start_w) state_d = ST_RUN;
            end
            default: begin
               state_d = ST_IDLE;
               pre_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      carry_w[0] = tick_w;
      for (int i = 0; i < 4; i++) begin
         carry_w[i+1] = carry_w[i] & wrap_w[i];
      end
   end

   // Digit order: sec_ones, sec_tens, min_ones, min_tens; units wrap at 9, tens at 5.
   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] MAX_V = ((gi % 2) == 0) ? 4'd9 : 4'd5;

      assign wrap_w[gi]  = (digit_q[gi] == MAX_V);
      assign digit_d[gi] = clear_all_w ? 4'd0 :
                           !carry_w[gi] ? digit_q[gi] :
                           wrap_w[gi]   ? 4'd0 : digit_q[gi] + 4'd1;
   end

   assign running_d  = (state_d == ST_RUN);
   assign rollover_d = carry_w[4];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         digit_q    <= '0;
         running_q  <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         digit_q    <= digit_d;
         running_q  <= running_d;
         rollover_q <= rollover_d;
      end
   end

   assign sec_ones = digit_q[0];
   assign sec_tens = digit_q[1];
   assign min_ones = digit_q[2];
   assign min_tens = digit_q[3];
   assign running  = running_q;
   assign rollover = rollover_q;

endmodule
